// File: rtl/decode_stage.sv
// Decode stage: register file with write-back port, custom-ISA control decode,
// offset sign-extension, load-use hazard detection and the decode-to-execute register.
module decode_stage #(
    parameter int unsigned REG_COUNT = 32,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    input  logic        flush,
    input  logic        wb_enable,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        d_stall,
    output logic        e_valid,
    output logic [31:0] e_pc,
    output logic [1:0]  e_alu_op,
    output logic [31:0] e_src_a,
    output logic [31:0] e_src_b,
    output logic [31:0] e_imm,
    output logic [4:0]  e_dst_reg,
    output logic [4:0]  e_src_reg_1,
    output logic [4:0]  e_src_reg_2,
    output logic        e_reg_write,
    output logic        e_mem_read,
    output logic        e_mem_write,
    output logic        e_mem_byte,
    output logic        e_branch,
    output logic        e_jump,
    output logic        e_illegal
);

    typedef enum logic [6:0] {
        OP_ADD  = 7'h00,
        OP_SUB  = 7'h01,
        OP_MUL  = 7'h02,
        OP_LDB  = 7'h10,
        OP_LDW  = 7'h11,
        OP_STB  = 7'h12,
        OP_STW  = 7'h13,
        OP_BEQ  = 7'h30,
        OP_JUMP = 7'h31,
        OP_NOP  = 7'h7F
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  alu_op;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_byte;
        logic        branch;
        logic        jump;
        logic        illegal;
    } e_bundle_t;

    logic [31:0] r_rf [REG_COUNT];
    e_bundle_t   r_e;

    logic [6:0]  w_opcode;
    logic [4:0]  w_f_dst;
    logic [4:0]  w_f_src1;
    logic [4:0]  w_f_src2;
    logic [31:0] w_mem_imm;
    logic [31:0] w_brn_imm;
    logic [31:0] w_jmp_imm;
    e_bundle_t   w_dec;
    e_bundle_t   w_e_next;
    logic [31:0] w_rd_a;
    logic [31:0] w_rd_b;
    logic        w_stall;

    assign w_opcode = d_instr[31:25];
    assign w_f_dst  = d_instr[24:20];
    assign w_f_src1 = d_instr[19:15];
    assign w_f_src2 = d_instr[14:10];

    assign w_mem_imm = {{17{d_instr[14]}}, d_instr[14:0]};
    assign w_brn_imm = {{17{d_instr[24]}}, d_instr[24:20], d_instr[9:0]};
    assign w_jmp_imm = {{12{d_instr[24]}}, d_instr[24:20], d_instr[14:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rf <= '{default: '0};
        end else if (wb_enable && (wb_reg != '0) && (32'(wb_reg) < REG_COUNT)) begin
            r_rf[wb_reg] <= wb_data;
        end
    end

    // rs1/rs2 hold only the registers this opcode actually reads (0 otherwise),
    // so operand fetch and hazard compare need no separate "used" flags.
    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        w_dec.pc    = d_pc;
        case (w_opcode)
            OP_ADD, OP_SUB, OP_MUL: begin
                w_dec.reg_write = 1'b1;
                w_dec.dst       = w_f_dst;
                w_dec.rs1       = w_f_src1;
                w_dec.rs2       = w_f_src2;
                w_dec.alu_op    = (w_opcode == OP_SUB) ? ALU_SUB :
                                  (w_opcode == OP_MUL) ? ALU_MUL : ALU_ADD;
            end
            OP_LDB, OP_LDW: begin
                w_dec.reg_write = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.mem_byte  = (w_opcode == OP_LDB);
                w_dec.alu_op    = ALU_ADD;
                w_dec.dst       = w_f_dst;
                w_dec.rs1       = w_f_src1;
                w_dec.imm       = w_mem_imm;
            end
            OP_STB, OP_STW: begin
                w_dec.mem_write = 1'b1;
                w_dec.mem_byte  = (w_opcode == OP_STB);
                w_dec.alu_op    = ALU_ADD;
                w_dec.rs1       = w_f_src1;
                w_dec.rs2       = w_f_dst;
                w_dec.imm       = w_mem_imm;
            end
            OP_BEQ: begin
                w_dec.branch = 1'b1;
                w_dec.alu_op = ALU_SUB;
                w_dec.rs1    = w_f_src1;
                w_dec.rs2    = w_f_src2;
                w_dec.imm    = w_brn_imm;
            end
            OP_JUMP: begin
                w_dec.jump = 1'b1;
                w_dec.imm  = w_jmp_imm;
            end
            OP_NOP: begin
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_rd_a = '0;
        if ((w_dec.rs1 != '0) && (32'(w_dec.rs1) < REG_COUNT)) begin
            w_rd_a = r_rf[w_dec.rs1];
            if (WB_BYPASS && wb_enable && (wb_reg == w_dec.rs1)) begin
                w_rd_a = wb_data;
            end
        end
    end

    always_comb begin
        w_rd_b = '0;
        if ((w_dec.rs2 != '0) && (32'(w_dec.rs2) < REG_COUNT)) begin
            w_rd_b = r_rf[w_dec.rs2];
            if (WB_BYPASS && wb_enable && (wb_reg == w_dec.rs2)) begin
                w_rd_b = wb_data;
            end
        end
    end

    always_comb begin
        w_e_next       = w_dec;
        w_e_next.src_a = w_rd_a;
        w_e_next.src_b = w_rd_b;
    end

    assign w_stall = r_e.valid && r_e.mem_read && (r_e.dst != '0) &&
                     ((r_e.dst == w_dec.rs1) || (r_e.dst == w_dec.rs2));
    assign d_stall = w_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_e <= '0;
        end else if (flush || w_stall) begin
            r_e <= '0;
        end else begin
            r_e <= w_e_next;
        end
    end

    assign e_valid     = r_e.valid;
    assign e_pc        = r_e.pc;
    assign e_alu_op    = r_e.alu_op;
    assign e_src_a     = r_e.src_a;
    assign e_src_b     = r_e.src_b;
    assign e_imm       = r_e.imm;
    assign e_dst_reg   = r_e.dst;
    assign e_src_reg_1 = r_e.rs1;
    assign e_src_reg_2 = r_e.rs2;
    assign e_reg_write = r_e.reg_write;
    assign e_mem_read  = r_e.mem_read;
    assign e_mem_write = r_e.mem_write;
    assign e_mem_byte  = r_e.mem_byte;
    assign e_branch    = r_e.branch;
    assign e_jump      = r_e.jump;
    assign e_illegal   = r_e.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// instruction streams compared against a behavioural model of the stage.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        flush;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        d_stall;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [1:0]  e_alu_op;
    logic [31:0] e_src_a;
    logic [31:0] e_src_b;
    logic [31:0] e_imm;
    logic [4:0]  e_dst_reg;
    logic [4:0]  e_src_reg_1;
    logic [4:0]  e_src_reg_2;
    logic        e_reg_write;
    logic        e_mem_read;
    logic        e_mem_write;
    logic        e_mem_byte;
    logic        e_branch;
    logic        e_jump;
    logic        e_illegal;

    always #5 clock = ~clock;

    decode_stage #(.REG_COUNT(32), .WB_BYPASS(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .d_instr    (d_instr),
        .d_pc       (d_pc),
        .flush      (flush),
        .wb_enable  (wb_enable),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .d_stall    (d_stall),
        .e_valid    (e_valid),
        .e_pc       (e_pc),
        .e_alu_op   (e_alu_op),
        .e_src_a    (e_src_a),
        .e_src_b    (e_src_b),
        .e_imm      (e_imm),
        .e_dst_reg  (e_dst_reg),
        .e_src_reg_1(e_src_reg_1),
        .e_src_reg_2(e_src_reg_2),
        .e_reg_write(e_reg_write),
        .e_mem_read (e_mem_read),
        .e_mem_write(e_mem_write),
        .e_mem_byte (e_mem_byte),
        .e_branch   (e_branch),
        .e_jump     (e_jump),
        .e_illegal  (e_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  alu;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_byte;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [31:0] m_rf [32];
    exp_t        m_e = '0;
    logic        last_stall = 1'b0;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [14:0] lo);
        return {op, d, s1, lo};
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] idx, input logic we,
                                       input logic [4:0] wreg, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'd0;
        if (we && wreg == idx) return wdata;
        return m_rf[idx];
    endfunction

    // Reference decode straight from the opcode table; offsets are
    // sign-extended with $signed arithmetic.
    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic we, input logic [4:0] wreg,
                                          input logic [31:0] wdata);
        exp_t        e;
        logic [6:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [14:0] mo;
        logic [14:0] bo;
        logic [19:0] jo;
        op = ins[31:25];
        d  = ins[24:20];
        s1 = ins[19:15];
        s2 = ins[14:10];
        mo = ins[14:0];
        bo = {ins[24:20], ins[9:0]};
        jo = {ins[24:20], ins[14:0]};
        e = '0;
        e.valid = 1'b1;
        e.pc = pc;
        case (op)
            7'h00, 7'h01, 7'h02: begin
                e.reg_write = 1'b1;
                e.dst = d; e.rs1 = s1; e.rs2 = s2;
                e.alu = (op == 7'h01) ? 2'b01 : (op == 7'h02) ? 2'b10 : 2'b00;
            end
            7'h10, 7'h11: begin
                e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_byte = (op == 7'h10);
                e.dst = d; e.rs1 = s1;
                e.imm = 32'($signed(mo));
            end
            7'h12, 7'h13: begin
                e.mem_write = 1'b1; e.mem_byte = (op == 7'h12);
                e.rs1 = s1; e.rs2 = d;
                e.imm = 32'($signed(mo));
            end
            7'h30: begin
                e.branch = 1'b1; e.alu = 2'b01;
                e.rs1 = s1; e.rs2 = s2;
                e.imm = 32'($signed(bo));
            end
            7'h31: begin
                e.jump = 1'b1;
                e.imm = 32'($signed(jo));
            end
            7'h7F: begin
            end
            default: e.illegal = 1'b1;
        endcase
        e.src_a = rd(e.rs1, we, wreg, wdata);
        e.src_b = rd(e.rs2, we, wreg, wdata);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_e();
        chk("e_valid",     32'(e_valid),     32'(m_e.valid));
        chk("e_pc",        e_pc,             m_e.pc);
        chk("e_alu_op",    32'(e_alu_op),    32'(m_e.alu));
        chk("e_src_a",     e_src_a,          m_e.src_a);
        chk("e_src_b",     e_src_b,          m_e.src_b);
        chk("e_imm",       e_imm,            m_e.imm);
        chk("e_dst_reg",   32'(e_dst_reg),   32'(m_e.dst));
        chk("e_src_reg_1", 32'(e_src_reg_1), 32'(m_e.rs1));
        chk("e_src_reg_2", 32'(e_src_reg_2), 32'(m_e.rs2));
        chk("e_reg_write", 32'(e_reg_write), 32'(m_e.reg_write));
        chk("e_mem_read",  32'(e_mem_read),  32'(m_e.mem_read));
        chk("e_mem_write", 32'(e_mem_write), 32'(m_e.mem_write));
        chk("e_mem_byte",  32'(e_mem_byte),  32'(m_e.mem_byte));
        chk("e_branch",    32'(e_branch),    32'(m_e.branch));
        chk("e_jump",      32'(e_jump),      32'(m_e.jump));
        chk("e_illegal",   32'(e_illegal),   32'(m_e.illegal));
    endtask

    // One clock: check d_stall against the model, advance the model, compare E.
    task automatic step();
        exp_t nxt;
        logic st;
        #1;
        nxt = model_decode(d_instr, d_pc, wb_enable, wb_reg, wb_data);
        st = m_e.valid && m_e.mem_read && (m_e.dst != 5'd0) &&
             ((m_e.dst == nxt.rs1) || (m_e.dst == nxt.rs2));
        chk("d_stall", 32'(d_stall), 32'(st));
        last_stall = st;
        if (reset || flush || st) m_e = '0;
        else m_e = nxt;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (wb_enable && wb_reg != 5'd0) begin
            m_rf[wb_reg] = wb_data;
        end
        @(posedge clock);
        #1;
        check_e();
    endtask

    initial begin
        logic [6:0] ops [12];
        ops = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13,
                7'h30, 7'h31, 7'h7F, 7'h05, 7'h11};

        // Reset for two cycles with a pending write-back to r3
        reset = 1'b1; flush = 1'b0; d_instr = 32'd0; d_pc = 32'd0;
        wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'h1234_5678;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_e = '0;
        check_e();
        chk("reset_e_valid", 32'(e_valid), 32'd0);

        // ADD r1,r3,r4 after reset: r3 was cleared
        reset = 1'b0; wb_enable = 1'b0;
        d_instr = mk(7'h00, 5'd1, 5'd3, {5'd4, 10'd0}); d_pc = 32'h100;
        step();
        chk("post_reset_src_a", e_src_a, 32'd0);

        // Write-back bypass into ADD r1,r3,r0
        wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD_BEEF;
        d_instr = mk(7'h00, 5'd1, 5'd3, 15'd0); d_pc = 32'h104;
        step();
        chk("bypass_src_a", e_src_a, 32'hDEAD_BEEF);
        chk("bypass_src_b", e_src_b, 32'd0);
        chk("bypass_alu", 32'(e_alu_op), 32'd0);
        chk("bypass_reg_write", 32'(e_reg_write), 32'd1);

        // r2 = 0x100 via a NOP cycle
        wb_enable = 1'b1; wb_reg = 5'd2; wb_data = 32'h100;
        d_instr = mk(7'h7F, 5'd0, 5'd0, 15'd0); d_pc = 32'h108;
        step();

        // Load-use: LDW r5,[r2+4] then ADD r6,r5,r2
        wb_enable = 1'b0;
        d_instr = mk(7'h11, 5'd5, 5'd2, 15'd4); d_pc = 32'h10C;
        step();
        d_instr = mk(7'h00, 5'd6, 5'd5, {5'd2, 10'd0}); d_pc = 32'h110;
        #1;
        chk("loaduse_stall", 32'(d_stall), 32'd1);
        step();
        chk("loaduse_bubble", 32'(e_valid), 32'd0);
        chk("loaduse_released", 32'(d_stall), 32'd0);
        step();
        chk("loaduse_add_src1", 32'(e_src_reg_1), 32'd5);
        chk("loaduse_add_valid", 32'(e_valid), 32'd1);

        // LDW r5 followed by JUMP whose offset field happens to equal 5
        d_instr = mk(7'h11, 5'd5, 5'd2, 15'd4); d_pc = 32'h114;
        step();
        d_instr = mk(7'h31, 5'd5, 5'd5, {5'd5, 10'd0}); d_pc = 32'h118;
        step();
        chk("jump_no_stall_valid", 32'(e_valid), 32'd1);

        // LDB r1,[r2+0x4000]: negative offset
        d_instr = mk(7'h10, 5'd1, 5'd2, 15'h4000); d_pc = 32'h11C;
        step();
        chk("ldb_imm", e_imm, 32'hFFFF_C000);
        chk("ldb_byte", 32'(e_mem_byte), 32'd1);
        chk("ldb_read", 32'(e_mem_read), 32'd1);

        // JUMP with [24:20]=0x10, [14:0]=0
        d_instr = mk(7'h31, 5'h10, 5'd0, 15'd0); d_pc = 32'h120;
        step();
        chk("jump_imm", e_imm, 32'hFFF8_0000);
        chk("jump_flag", 32'(e_jump), 32'd1);

        // Flush with SUB in D
        flush = 1'b1;
        d_instr = mk(7'h01, 5'd7, 5'd2, {5'd3, 10'd0}); d_pc = 32'h124;
        step();
        chk("flush_valid", 32'(e_valid), 32'd0);
        chk("flush_reg_write", 32'(e_reg_write), 32'd0);
        flush = 1'b0;

        // Write to r0 ignored, then read r0
        wb_enable = 1'b1; wb_reg = 5'd0; wb_data = 32'h55;
        d_instr = mk(7'h00, 5'd1, 5'd0, 15'd0); d_pc = 32'h128;
        step();
        wb_enable = 1'b0;
        step();
        chk("r0_reads_zero", e_src_a, 32'd0);

        // Undefined opcode
        d_instr = mk(7'h05, 5'd1, 5'd2, 15'h1234); d_pc = 32'h12C;
        step();
        chk("illegal_flag", 32'(e_illegal), 32'd1);
        chk("illegal_valid", 32'(e_valid), 32'd1);
        chk("illegal_reg_write", 32'(e_reg_write), 32'd0);

        // Random streams; instruction held while stalled, as upstream would
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                logic [6:0] op;
                op = ops[$urandom_range(0, 11)];
                if ($urandom_range(0, 9) == 0) op = 7'($urandom);
                d_instr = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             {5'($urandom_range(0, 7)), 10'($urandom)});
                d_pc = $urandom;
            end
            wb_enable = 1'($urandom_range(0, 1));
            wb_reg = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch-to-decode register. Consumes d_instr/d_pc.
- Contains the 32x32 register file with a write-back port, control decode for the custom ISA, offset sign-extension and load-use hazard detection.
- Ends in the decode-to-execute pipeline register, which supports stall-bubble and flush.

Parameters:
- REG_COUNT, 32, number of architectural registers; register 0 always reads zero.
- WB_BYPASS, 1, 1 = a write-back to a register in the same cycle it is read returns wb_data.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- d_instr  in  32  instruction from the f2d register.
- d_pc  in  32  PC of d_instr.
- flush  in  1  kill the instruction entering E (branch/jump taken downstream).
- wb_enable  in  1  register-file write enable.
- wb_reg  in  5  write-back destination.
- wb_data  in  32  write-back value.
- d_stall  out  1  combinational; the upstream PC and f2d register hold when 1.
- e_valid  out  1  the E-stage instruction is real (0 = bubble).
- e_pc  out  32  PC of the E-stage instruction.
- e_alu_op  out  2  00 add, 01 sub, 10 mul.
- e_src_a  out  32  operand A.
- e_src_b  out  32  operand B / store data.
- e_imm  out  32  sign-extended offset.
- e_dst_reg  out  5  destination register.
- e_src_reg_1  out  5  source register numbers, for downstream forwarding.
- e_src_reg_2  out  5  source register numbers, for downstream forwarding.
- e_reg_write  out  1  control flag.
- e_mem_read  out  1  control flag.
- e_mem_write  out  1  control flag.
- e_mem_byte  out  1  control flag.
- e_branch  out  1  control flag.
- e_jump  out  1  control flag.
- e_illegal  out  1  control flag.

Behaviour:
- Fields:
  - opcode = [31:25]; dst = [24:20]; src1 = [19:15]; src2 = [14:10].
  - mem_off = [14:0]; brn_off = {[24:20],[9:0]}; jmp_off = {[24:20],[14:0]}.
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 MUL: reg_write; srcA = R[src1], srcB = R[src2].
  - 0x10 LDB, 0x11 LDW: reg_write and mem_read; alu add; srcA = R[src1]; imm = sext(mem_off); mem_byte for LDB.
  - 0x12 STB, 0x13 STW: mem_write; alu add; srcA = R[src1]; srcB = R[dst] (store data); imm = sext(mem_off).
  - 0x30 BEQ: branch; alu sub; srcA = R[src1], srcB = R[src2]; imm = sext(brn_off).
  - 0x31 JUMP: jump; imm = sext(jmp_off); no register reads.
  - 0x7F NOP, and any other opcode: all control flags 0. Undefined opcodes (anything not listed, including 0x7F's complement set) also set e_illegal = 1, with e_valid = 1.
- Sign-extension:
  - 15-bit offsets replicate bit 14 up to 32 bits.
  - The 20-bit offset replicates bit 19.
- Register file:
  - Written on the rising edge when wb_enable = 1 and wb_reg != 0.
  - Writes to r0 are ignored; reads of r0 return 0.
  - Reads are combinational.
  - With WB_BYPASS = 1, a read of register N while wb_enable = 1 and wb_reg = N (N != 0) returns wb_data in the same cycle.
- Hazard:
  - d_stall = e_valid & e_mem_read & (e_dst_reg != 0) & (e_dst_reg matches a register the D instruction reads, per the opcode table).
  - Unused fields never cause a stall.
- E-register update, one cycle latency, in priority order:
  1. reset: all e_* outputs 0; all registers 0.
  2. flush: load a bubble (all e_* 0, including e_valid).
  3. d_stall: load a bubble; upstream holds, so the same D instruction re-evaluates next cycle.
  4. Otherwise: load the decoded D instruction with e_valid = 1.
- The instruction present after reset (f2d reset value 0x00000000) decodes as ADD r0,r0,r0. This is harmless because writes to r0 are ignored.
- flush and d_stall in the same cycle: flush wins. d_stall is still driven combinationally; upstream resolves it.
- Reset mid-operation: the next cycle shows a bubble in E and a zeroed register file, regardless of wb_enable.

Test Plan:
- Reset asserted for 2 cycles with wb_enable = 1, wb_reg = 3 → e_valid = 0, all e_* 0. A following ADD r1,r3,r4 gives e_src_a = 0.
- wb_enable = 1, wb_reg = 3, wb_data = 0xDEADBEEF in the same cycle as ADD r1,r3,r0 → next cycle e_src_a = 0xDEADBEEF, e_src_b = 0, e_alu_op = 00, e_reg_write = 1.
- LDW r5,[r2+4] then ADD r6,r5,r2 → d_stall = 1 for exactly one cycle, E shows a bubble, then ADD with e_src_reg_1 = 5.
- Control case: LDW r5 then JUMP → no stall.
- LDB r1,[r2+0x4000] → e_imm = 0xFFFFC000, e_mem_byte = 1, e_mem_read = 1.
- JUMP with [24:20] = 0x10, [14:0] = 0 → e_imm = 0xFFF80000, e_jump = 1.
- flush = 1 with SUB in D → next cycle e_valid = 0, e_reg_write = 0.
- wb_reg = 0, wb_data = 0x55 → r0 still reads 0.
- Opcode 0x05 → e_valid = 1, e_illegal = 1, all other flags 0.
